// File: rtl/flag_gen_pkg.sv
// Shared opcode encodings and status-flag bit positions for the calculator ALU,
// flag generator and status-flag register.
package flag_gen_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned FLAGS_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OP_W-1:0] OP_MUL  = 3'b010;
    localparam logic [OP_W-1:0] OP_DIV  = 3'b011;
    localparam logic [OP_W-1:0] OP_AND  = 3'b100;
    localparam logic [OP_W-1:0] OP_OR   = 3'b101;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b110;
    localparam logic [OP_W-1:0] OP_PASS = 3'b111;

    localparam int unsigned FLG_V = 0;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_N = 2;
    localparam int unsigned FLG_Z = 3;

    // Places individual flags at their register bit positions.
    function automatic logic [FLAGS_W-1:0] pack_flags(
        input logic v,
        input logic c,
        input logic n,
        input logic z
    );
        logic [FLAGS_W-1:0] f;
        f        = '0;
        f[FLG_V] = v;
        f[FLG_C] = c;
        f[FLG_N] = n;
        f[FLG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/flag_calc.sv
// Combinational OVERFLOW/CARRY/NEGATIVE/ZERO evaluation from opcode, operands
// and the ALU result.
module flag_calc
    import flag_gen_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [OP_W-1:0]    i_op,
    input  logic [W-1:0]       i_a,
    input  logic [W-1:0]       i_b,
    input  logic [W-1:0]       i_r,
    input  logic [W-1:0]       i_r_hi,
    output logic [FLAGS_W-1:0] o_flags_c
);

    localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ALL_ONES = '1;

    logic w_v;
    logic w_c;
    logic w_n;
    logic w_z;
    logic w_sa;
    logic w_sb;
    logic w_sr;

    assign w_sa = i_a[W-1];
    assign w_sb = i_b[W-1];
    assign w_sr = i_r[W-1];

    always_comb begin
        w_v = 1'b0;
        w_c = 1'b0;
        w_z = (i_r == '0);
        w_n = w_sr;
        case (i_op)
            // Carry-out of A+B exists exactly when A exceeds 2^W-1-B, i.e. ~B.
            OP_ADD: begin
                w_c = (i_a > ~i_b);
                w_v = (w_sa == w_sb) && (w_sr != w_sa);
            end
            OP_SUB: begin
                w_c = (i_a < i_b);
                w_v = (w_sa != w_sb) && (w_sr != w_sa);
            end
            OP_MUL: begin
                w_v = (i_r_hi != {W{w_sr}});
                w_c = (i_r_hi != '0);
            end
            // Divide-by-zero result is meaningless, so Z/N are suppressed.
            OP_DIV: begin
                w_v = (i_b == '0) || ((i_a == MIN_NEG) && (i_b == ALL_ONES));
                if (i_b == '0) begin
                    w_z = 1'b0;
                    w_n = 1'b0;
                end
            end
            default: begin
                w_v = 1'b0;
                w_c = 1'b0;
            end
        endcase
        o_flags_c = pack_flags(w_v, w_c, w_n, w_z);
    end

endmodule

// File: rtl/flag_gen.sv
// Two-stage valid/ready pipeline from the ALU to the status-flag register, with a
// sticky overflow error latch for the display.
module flag_gen
    import flag_gen_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [OP_W-1:0]    OP,
    input  logic [W-1:0]       A,
    input  logic [W-1:0]       B,
    input  logic [W-1:0]       R,
    input  logic [W-1:0]       R_HI,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [FLAGS_W-1:0] FLAGS_OUT,
    output logic               FLAGS_EN,
    output logic               ERR,
    input  logic               CLR_ERR
);

    logic               r_s1_v;
    logic [OP_W-1:0]    r_s1_op;
    logic [W-1:0]       r_s1_a;
    logic [W-1:0]       r_s1_b;
    logic [W-1:0]       r_s1_r;
    logic [W-1:0]       r_s1_r_hi;
    logic               r_s2_v;
    logic [FLAGS_W-1:0] r_flags;
    logic               r_err;

    logic               w_s1_adv;
    logic               w_in_ready;
    logic               w_flags_en;
    logic [FLAGS_W-1:0] w_flags;

    assign w_s1_adv   = !r_s2_v || OUT_READY;
    assign w_in_ready = !RST && (!r_s1_v || w_s1_adv);
    assign w_flags_en = r_s2_v && OUT_READY;

    flag_calc #(
        .W (W)
    ) u_calc (
        .i_op      (r_s1_op),
        .i_a       (r_s1_a),
        .i_b       (r_s1_b),
        .i_r       (r_s1_r),
        .i_r_hi    (r_s1_r_hi),
        .o_flags_c (w_flags)
    );

    // Stage 1 holds the raw bundle, stage 2 the computed flag vector.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1_v    <= 1'b0;
            r_s1_op   <= '0;
            r_s1_a    <= '0;
            r_s1_b    <= '0;
            r_s1_r    <= '0;
            r_s1_r_hi <= '0;
            r_s2_v    <= 1'b0;
            r_flags   <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_flags <= w_flags;
                end
            end
            if (w_in_ready) begin
                r_s1_v <= IN_VALID;
                if (IN_VALID) begin
                    r_s1_op   <= OP;
                    r_s1_a    <= A;
                    r_s1_b    <= B;
                    r_s1_r    <= R;
                    r_s1_r_hi <= R_HI;
                end
            end
            // A new overflow transfer takes priority over a clear request.
            if (w_flags_en && r_flags[FLG_V]) begin
                r_err <= 1'b1;
            end else if (CLR_ERR) begin
                r_err <= 1'b0;
            end
        end
    end

    assign IN_READY  = w_in_ready;
    assign OUT_VALID = r_s2_v;
    assign FLAGS_OUT = r_flags;
    assign FLAGS_EN  = w_flags_en;
    assign ERR       = r_err;

endmodule

// File: tb/tb_flag_gen.sv
// Bench for flag_gen: directed flag vectors, error latch, backpressure, reset
// flush, and randomized traffic against an arithmetic reference model.
module tb_flag_gen;
    import flag_gen_pkg::*;

    localparam int unsigned W = 8;

    logic       CLK = 1'b0;
    logic       RST;
    logic       IN_VALID;
    logic       IN_READY;
    logic [2:0] OP;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] R;
    logic [7:0] R_HI;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [3:0] FLAGS_OUT;
    logic       FLAGS_EN;
    logic       ERR;
    logic       CLR_ERR;

    int n_checks = 0;
    int n_pass   = 0;
    logic exp_err = 1'b0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic [7:0] rhi;
        logic [3:0] exp;
    } vec_t;

    flag_gen #(.W(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OP        (OP),
        .A         (A),
        .B         (B),
        .R         (R),
        .R_HI      (R_HI),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .FLAGS_OUT (FLAGS_OUT),
        .FLAGS_EN  (FLAGS_EN),
        .ERR       (ERR),
        .CLR_ERR   (CLR_ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    // Hand-derived directed vectors: {Z,N,C,V}
    localparam logic [2:0] D_OP [12] = '{OP_ADD, OP_SUB, OP_ADD, OP_DIV, OP_DIV, OP_MUL,
                                         OP_AND, OP_MUL, OP_SUB, OP_XOR, OP_PASS, OP_OR};
    localparam logic [7:0] D_A  [12] = '{8'h7F, 8'h00, 8'hFF, 8'h05, 8'h80, 8'h10,
                                         8'hF0, 8'hFE, 8'h80, 8'hAA, 8'h80, 8'h01};
    localparam logic [7:0] D_B  [12] = '{8'h01, 8'h01, 8'h01, 8'h00, 8'hFF, 8'h10,
                                         8'h0F, 8'h03, 8'h01, 8'hAA, 8'h33, 8'h80};
    localparam logic [7:0] D_R  [12] = '{8'h80, 8'hFF, 8'h00, 8'h3C, 8'h01, 8'h00,
                                         8'h00, 8'hFA, 8'h7F, 8'h00, 8'h80, 8'h81};
    localparam logic [7:0] D_RH [12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                                         8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h55};
    localparam logic [3:0] D_EX [12] = '{4'b0101, 4'b0110, 4'b1010, 4'b0001, 4'b0001, 4'b1011,
                                         4'b1000, 4'b0110, 4'b0001, 4'b1000, 4'b0100, 4'b0100};

    // Flags from the mathematical meaning of each operation on integers.
    function automatic logic [3:0] ref_flags(input vec_t v);
        int  ua  = int'(v.a);
        int  ub  = int'(v.b);
        int  sa  = int'($signed(v.a));
        int  sb  = int'($signed(v.b));
        int  res;
        bit  vf  = 1'b0;
        bit  cf  = 1'b0;
        bit  zf  = (v.r == 8'h00);
        bit  nf  = ($signed(v.r) < 0);
        case (v.op)
            OP_ADD: begin res = sa + sb; vf = (res > 127) || (res < -128); cf = (ua + ub) > 255; end
            OP_SUB: begin res = sa - sb; vf = (res > 127) || (res < -128); cf = ua < ub; end
            OP_MUL: begin res = sa * sb; vf = (res > 127) || (res < -128); cf = (res < 0) || (res > 255); end
            OP_DIV: begin
                if (ub == 0) begin vf = 1'b1; zf = 1'b0; nf = 1'b0; end
                else vf = (sa == -128) && (sb == -1);
            end
            default: begin vf = 1'b0; cf = 1'b0; end
        endcase
        return {zf, nf, cf, vf};
    endfunction

    // Builds a bundle carrying the true ALU result for the operands.
    function automatic vec_t make_vec(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        vec_t v;
        int   sa = int'($signed(a));
        int   sb = int'($signed(b));
        int   p;
        v.op  = op;
        v.a   = a;
        v.b   = b;
        v.rhi = 8'($urandom);
        case (op)
            OP_ADD: v.r = a + b;
            OP_SUB: v.r = a - b;
            OP_MUL: begin p = sa * sb; v.r = p[7:0]; v.rhi = p[15:8]; end
            OP_DIV: begin
                if (b == 8'h00) v.r = 8'($urandom);
                else if (sa == -128 && sb == -1) v.r = 8'h80;
                else v.r = 8'(sa / sb);
            end
            OP_AND: v.r = a & b;
            OP_OR:  v.r = a | b;
            OP_XOR: v.r = a ^ b;
            default: v.r = a;
        endcase
        v.exp = ref_flags(v);
        return v;
    endfunction

    task automatic drive_vec(input vec_t v);
        OP = v.op; A = v.a; B = v.b; R = v.r; R_HI = v.rhi;
    endtask

    task automatic test_reset();
        RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1; CLR_ERR = 1'b0;
        OP = '0; A = '0; B = '0; R = '0; R_HI = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK); #1;
        n_checks++; if (IN_READY !== 1'b0) $display("FAIL rst_in_ready: got %b expected 0", IN_READY); else n_pass++;
        n_checks++; if (OUT_VALID !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", OUT_VALID); else n_pass++;
        n_checks++; if (FLAGS_OUT !== 4'b0000) $display("FAIL rst_flags: got %b expected 0000", FLAGS_OUT); else n_pass++;
        n_checks++; if (ERR !== 1'b0) $display("FAIL rst_err: got %b expected 0", ERR); else n_pass++;
        RST = 1'b0; #1;
        n_checks++; if (IN_READY !== 1'b1) $display("FAIL rst_release_ready: got %b expected 1", IN_READY); else n_pass++;
        exp_err = 1'b0;
    endtask

    task automatic test_directed();
        vec_t v;
        for (int i = 0; i < 12; i++) begin
            v.op = D_OP[i]; v.a = D_A[i]; v.b = D_B[i]; v.r = D_R[i]; v.rhi = D_RH[i]; v.exp = D_EX[i];
            @(negedge CLK);
            drive_vec(v); IN_VALID = 1'b1; #1;
            n_checks++; if (IN_READY !== 1'b1) $display("FAIL dir_ready[%0d]: got %b expected 1", i, IN_READY); else n_pass++;
            @(posedge CLK); #1;
            IN_VALID = 1'b0;
            n_checks++; if (OUT_VALID !== 1'b0) $display("FAIL dir_early[%0d]: got %b expected 0", i, OUT_VALID); else n_pass++;
            @(posedge CLK); #1;
            n_checks++; if (OUT_VALID !== 1'b1) $display("FAIL dir_valid[%0d]: got %b expected 1", i, OUT_VALID); else n_pass++;
            n_checks++; if (FLAGS_OUT !== v.exp) $display("FAIL dir_flags[%0d]: got %b expected %b", i, FLAGS_OUT, v.exp); else n_pass++;
            n_checks++; if (FLAGS_EN !== 1'b1) $display("FAIL dir_en[%0d]: got %b expected 1", i, FLAGS_EN); else n_pass++;
            if (v.exp[0]) exp_err = 1'b1;
            @(posedge CLK); #1;
            n_checks++; if (ERR !== exp_err) $display("FAIL dir_err[%0d]: got %b expected %b", i, ERR, exp_err); else n_pass++;
            n_checks++; if (OUT_VALID !== 1'b0) $display("FAIL dir_drained[%0d]: got %b expected 0", i, OUT_VALID); else n_pass++;
        end
    endtask

    task automatic test_err_clear();
        vec_t v;
        v = make_vec(OP_ADD, 8'h7F, 8'h01);
        @(negedge CLK); CLR_ERR = 1'b1;
        @(posedge CLK); #1; CLR_ERR = 1'b0;
        n_checks++; if (ERR !== 1'b0) $display("FAIL err_clear: got %b expected 0", ERR); else n_pass++;
        @(negedge CLK); drive_vec(v); IN_VALID = 1'b1;
        @(posedge CLK); #1; IN_VALID = 1'b0;
        @(posedge CLK); #1;
        n_checks++; if (FLAGS_EN !== 1'b1 || FLAGS_OUT !== 4'b0101)
            $display("FAIL err_vec: got en=%b flags=%b expected en=1 flags=0101", FLAGS_EN, FLAGS_OUT); else n_pass++;
        CLR_ERR = 1'b1;
        @(posedge CLK); #1; CLR_ERR = 1'b0;
        n_checks++; if (ERR !== 1'b1) $display("FAIL err_set_wins: got %b expected 1", ERR); else n_pass++;
        @(negedge CLK); CLR_ERR = 1'b1;
        @(posedge CLK); #1; CLR_ERR = 1'b0;
        n_checks++; if (ERR !== 1'b0) $display("FAIL err_clear2: got %b expected 0", ERR); else n_pass++;
        exp_err = 1'b0;
    endtask

    task automatic test_backpressure();
        vec_t bp[4];
        int   idx  = 0;
        int   nout = 0;
        bp[0] = make_vec(OP_ADD, 8'h7F, 8'h01);
        bp[1] = make_vec(OP_SUB, 8'h00, 8'h01);
        bp[2] = make_vec(OP_MUL, 8'h10, 8'h10);
        bp[3] = make_vec(OP_XOR, 8'h3C, 8'hC3);
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            OUT_READY = 1'b0;
            if (idx < 4) begin drive_vec(bp[idx]); IN_VALID = 1'b1; end else IN_VALID = 1'b0;
            #1;
            n_checks++; if (FLAGS_EN !== 1'b0) $display("FAIL bp_no_en[%0d]: got %b expected 0", c, FLAGS_EN); else n_pass++;
            if (OUT_VALID === 1'b1) begin
                n_checks++; if (FLAGS_OUT !== bp[0].exp) $display("FAIL bp_hold[%0d]: got %b expected %b", c, FLAGS_OUT, bp[0].exp); else n_pass++;
            end
            if (IN_VALID && IN_READY) idx++;
        end
        @(negedge CLK); #1;
        n_checks++; if (idx != 2) $display("FAIL bp_accepts: got %0d expected 2", idx); else n_pass++;
        n_checks++; if (IN_READY !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0", IN_READY); else n_pass++;
        n_checks++; if (OUT_VALID !== 1'b1 || FLAGS_OUT !== bp[0].exp)
            $display("FAIL bp_held: got valid=%b flags=%b expected valid=1 flags=%b", OUT_VALID, FLAGS_OUT, bp[0].exp); else n_pass++;
        for (int c = 0; c < 20 && nout < 4; c++) begin
            @(negedge CLK);
            OUT_READY = 1'b1;
            if (idx < 4) begin drive_vec(bp[idx]); IN_VALID = 1'b1; end else IN_VALID = 1'b0;
            #1;
            if (FLAGS_EN === 1'b1) begin
                n_checks++; if (FLAGS_OUT !== bp[nout].exp) $display("FAIL bp_order[%0d]: got %b expected %b", nout, FLAGS_OUT, bp[nout].exp); else n_pass++;
                if (bp[nout].exp[0]) exp_err = 1'b1;
                nout++;
            end
            if (IN_VALID && IN_READY) idx++;
        end
        n_checks++; if (nout != 4) $display("FAIL bp_count: got %0d expected 4", nout); else n_pass++;
        @(negedge CLK); IN_VALID = 1'b0; #1;
        n_checks++; if (FLAGS_EN !== 1'b0 || OUT_VALID !== 1'b0)
            $display("FAIL bp_no_dup: got en=%b valid=%b expected 0 0", FLAGS_EN, OUT_VALID); else n_pass++;
        n_checks++; if (ERR !== exp_err) $display("FAIL bp_err: got %b expected %b", ERR, exp_err); else n_pass++;
    endtask

    task automatic test_random();
        vec_t       v;
        logic [3:0] q[$];
        logic [3:0] front;
        logic [7:0] a, b;
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            a = 8'($urandom); b = 8'($urandom);
            if ($urandom_range(0, 7) == 0) b = 8'h00;
            if ($urandom_range(0, 7) == 0) begin a = 8'h80; b = 8'hFF; end
            v = make_vec(3'($urandom_range(0, 7)), a, b);
            drive_vec(v);
            IN_VALID  = ($urandom_range(0, 3) != 0);
            OUT_READY = ($urandom_range(0, 3) != 0);
            CLR_ERR   = ($urandom_range(0, 15) == 0);
            #1;
            n_checks++; if (IN_READY !== ((q.size() < 2) || OUT_READY))
                $display("FAIL rnd_in_ready[%0d]: got %b expected %b", c, IN_READY, (q.size() < 2) || OUT_READY); else n_pass++;
            if (FLAGS_EN === 1'b1) begin
                n_checks++;
                if (q.size() == 0) $display("FAIL rnd_spurious[%0d]: got en=1 expected en=0", c);
                else begin
                    front = q.pop_front();
                    if (FLAGS_OUT !== front) $display("FAIL rnd_flags[%0d]: got %b expected %b", c, FLAGS_OUT, front);
                    else n_pass++;
                    if (front[0]) exp_err = 1'b1;
                    else if (CLR_ERR) exp_err = 1'b0;
                end
            end else if (CLR_ERR) exp_err = 1'b0;
            if (IN_VALID && IN_READY) q.push_back(v.exp);
            @(posedge CLK); #1;
            n_checks++; if (ERR !== exp_err) $display("FAIL rnd_err[%0d]: got %b expected %b", c, ERR, exp_err); else n_pass++;
        end
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            @(negedge CLK);
            IN_VALID = 1'b0; OUT_READY = 1'b1; CLR_ERR = 1'b0;
            #1;
            if (FLAGS_EN === 1'b1) begin
                front = q.pop_front();
                n_checks++; if (FLAGS_OUT !== front) $display("FAIL rnd_drain_flags: got %b expected %b", FLAGS_OUT, front); else n_pass++;
                if (front[0]) exp_err = 1'b1;
            end
        end
        n_checks++; if (q.size() != 0) $display("FAIL rnd_drain: got %0d pending expected 0", q.size()); else n_pass++;
    endtask

    task automatic test_reset_full();
        vec_t v;
        v = make_vec(OP_ADD, 8'h7F, 8'h01);
        @(negedge CLK); OUT_READY = 1'b0; CLR_ERR = 1'b0; drive_vec(v); IN_VALID = 1'b1;
        @(posedge CLK);
        @(negedge CLK); v = make_vec(OP_SUB, 8'h00, 8'h01); drive_vec(v);
        @(posedge CLK);
        @(negedge CLK); IN_VALID = 1'b0; #1;
        n_checks++; if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0)
            $display("FAIL rf_full: got valid=%b ready=%b expected 1 0", OUT_VALID, IN_READY); else n_pass++;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; OUT_READY = 1'b1;
        n_checks++; if (OUT_VALID !== 1'b0) $display("FAIL rf_valid: got %b expected 0", OUT_VALID); else n_pass++;
        n_checks++; if (FLAGS_OUT !== 4'b0000) $display("FAIL rf_flags: got %b expected 0000", FLAGS_OUT); else n_pass++;
        n_checks++; if (ERR !== 1'b0) $display("FAIL rf_err: got %b expected 0", ERR); else n_pass++;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK); #1;
            n_checks++; if (FLAGS_EN !== 1'b0) $display("FAIL rf_no_en[%0d]: got %b expected 0", c, FLAGS_EN); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_err_clear();
        test_backpressure();
        test_random();
        test_reset_full();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
